// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32 control FSM: FETCH/DECODE/EXECUTE/MEM/WRITEBACK/TRAP.
// In: clk, rst_n, instr, mem_ready, branch_taken. Out: datapath controls,
// memory strobes, IR/PC load, trap flag, FSM state and retired count.
module multicycle_control_unit #(
  parameter bit ENABLE_LOADSTORE = 1'b1,
  parameter bit ENABLE_UPPER     = 1'b1,
  parameter int CNT_W            = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      instr,
  input  logic             mem_ready,
  input  logic             branch_taken,
  output logic             ir_write,
  output logic             pc_write,
  output logic [1:0]       pc_src,
  output logic             mem_req,
  output logic             mem_we,
  output logic             mem_addr_src,
  output logic [3:0]       alu_op,
  output logic [1:0]       alu_a_src,
  output logic             alu_b_src,
  output logic [2:0]       branch_cond,
  output logic             reg_write_en,
  output logic [1:0]       rd_src,
  output logic             illegal_instr,
  output logic [2:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;

  state_t state_q, state_d;
  logic   ill_q;
  logic   ir_w, pc_w, mreq, mwe, rwe;

  logic [6:0] opc;
  logic [2:0] f3;
  logic       f7b;
  logic       unused_bits;

  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign f7b = instr[30];
  assign unused_bits = ^{instr[31], instr[29:15], instr[11:7]};

  logic is_r, is_i, is_br, is_jal, is_jalr;
  logic is_ld, is_st, is_lui, is_aui, legal;

  assign is_r    = (opc == OP_R);
  assign is_i    = (opc == OP_I);
  assign is_br   = (opc == OP_BR);
  assign is_jal  = (opc == OP_JAL);
  assign is_jalr = (opc == OP_JALR);
  assign is_ld   = ENABLE_LOADSTORE && (opc == OP_LOAD);
  assign is_st   = ENABLE_LOADSTORE && (opc == OP_STORE);
  assign is_lui  = ENABLE_UPPER && (opc == OP_LUI);
  assign is_aui  = ENABLE_UPPER && (opc == OP_AUIPC);
  assign legal   = is_r | is_i | is_br | is_jal | is_jalr
                 | is_ld | is_st | is_lui | is_aui;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_FETCH;
      ill_q   <= 1'b0;
      instret <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_DECODE && !legal)
        ill_q <= 1'b1;
      if (pc_write)
        instret <= instret + 1'b1;
    end
  end

  always_comb begin
    state_d      = state_q;
    ir_w         = 1'b0;
    pc_w         = 1'b0;
    mreq         = 1'b0;
    mwe          = 1'b0;
    rwe          = 1'b0;
    pc_src       = 2'b00;
    mem_addr_src = 1'b0;
    alu_op       = 4'b0000;
    alu_a_src    = 2'b00;
    alu_b_src    = 1'b0;
    branch_cond  = 3'b010;
    rd_src       = 2'b00;
    case (state_q)
      S_FETCH: begin
        mreq = 1'b1;
        if (mem_ready) begin
          ir_w    = 1'b1;
          state_d = S_DECODE;
        end
      end
      S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
      S_EXEC: begin
        unique case (1'b1)
          is_r: begin
            alu_op    = {f7b, f3};
            alu_a_src = 2'b01;
            alu_b_src = 1'b1;
            state_d   = S_WB;
          end
          is_i: begin
            // only shifts (f3=101) take the arithmetic bit from the imm
            alu_op    = {(f3 == 3'b101) & f7b, f3};
            alu_a_src = 2'b01;
            state_d   = S_WB;
          end
          is_lui: begin
            alu_a_src = 2'b10;
            state_d   = S_WB;
          end
          is_aui: state_d = S_WB;
          is_ld, is_st: begin
            alu_a_src = 2'b01;
            state_d   = S_MEM;
          end
          is_br: begin
            branch_cond = f3;
            pc_w        = 1'b1;
            pc_src      = {1'b0, branch_taken};
            state_d     = S_FETCH;
          end
          is_jal: begin
            branch_cond = 3'b011;
            rwe         = 1'b1;
            rd_src      = 2'b10;
            pc_w        = 1'b1;
            pc_src      = 2'b01;
            state_d     = S_FETCH;
          end
          is_jalr: begin
            alu_a_src   = 2'b01;
            branch_cond = 3'b011;
            rwe         = 1'b1;
            rd_src      = 2'b10;
            pc_w        = 1'b1;
            pc_src      = 2'b10;
            state_d     = S_FETCH;
          end
          default: state_d = S_TRAP;
        endcase
      end
      S_MEM: begin
        mreq         = 1'b1;
        mem_addr_src = 1'b1;
        mwe          = is_st;
        if (mem_ready) begin
          if (is_st) begin
            pc_w    = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end
      end
      S_WB: begin
        rwe     = 1'b1;
        rd_src  = is_ld ? 2'b01 : 2'b00;
        pc_w    = 1'b1;
        state_d = S_FETCH;
      end
      S_TRAP: state_d = S_TRAP;
      default: state_d = S_FETCH;
    endcase
  end

  // strobes are held low for the whole reset cycle
  assign ir_write      = rst_n & ir_w;
  assign pc_write      = rst_n & pc_w;
  assign mem_req       = rst_n & mreq;
  assign mem_we        = rst_n & mwe;
  assign reg_write_en  = rst_n & rwe;
  assign illegal_instr = ill_q;
  assign state         = state_q;

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Scoreboard bench for multicycle_control_unit: three configurations
// share stimulus; a negedge monitor checks the selected instance.
module tb_multicycle_control_unit;

  typedef struct packed {
    logic [2:0]  st;
    logic        irw;
    logic        pcw;
    logic [1:0]  pcs;
    logic        mreq;
    logic        mwe;
    logic        mas;
    logic [3:0]  aop;
    logic [1:0]  asrc;
    logic        bsrc;
    logic [2:0]  bc;
    logic        rwe;
    logic [1:0]  rds;
    logic        ill;
    logic [31:0] cnt;
  } obs_t;

  typedef struct {
    string nm;
    obs_t  e;
  } item_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        mem_ready;
  logic        branch_taken;

  logic       irw [3];
  logic       pcw [3];
  logic [1:0] pcs [3];
  logic       mreq [3];
  logic       mwe [3];
  logic       mas [3];
  logic [3:0] aop [3];
  logic [1:0] asrc [3];
  logic       bsrc [3];
  logic [2:0] bc [3];
  logic       rwe [3];
  logic [1:0] rds [3];
  logic       ill [3];
  logic [2:0] st [3];
  logic [31:0] cnt0, cnt1;
  logic [3:0]  cnt2;

  item_t q[$];
  int    sel = 0;
  int    cnt = 0;
  int    mask = 32'hFFFF_FFFF;
  int    checks = 0;
  int    errors = 0;

  always #5 clk = ~clk;

  multicycle_control_unit u0 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .ir_write(irw[0]), .pc_write(pcw[0]),
    .pc_src(pcs[0]), .mem_req(mreq[0]), .mem_we(mwe[0]),
    .mem_addr_src(mas[0]), .alu_op(aop[0]), .alu_a_src(asrc[0]),
    .alu_b_src(bsrc[0]), .branch_cond(bc[0]), .reg_write_en(rwe[0]),
    .rd_src(rds[0]), .illegal_instr(ill[0]), .state(st[0]),
    .instret(cnt0));

  multicycle_control_unit #(
    .ENABLE_LOADSTORE(1'b0), .ENABLE_UPPER(1'b0)
  ) u1 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .ir_write(irw[1]), .pc_write(pcw[1]),
    .pc_src(pcs[1]), .mem_req(mreq[1]), .mem_we(mwe[1]),
    .mem_addr_src(mas[1]), .alu_op(aop[1]), .alu_a_src(asrc[1]),
    .alu_b_src(bsrc[1]), .branch_cond(bc[1]), .reg_write_en(rwe[1]),
    .rd_src(rds[1]), .illegal_instr(ill[1]), .state(st[1]),
    .instret(cnt1));

  multicycle_control_unit #(.CNT_W(4)) u2 (
    .clk(clk), .rst_n(rst_n), .instr(instr), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .ir_write(irw[2]), .pc_write(pcw[2]),
    .pc_src(pcs[2]), .mem_req(mreq[2]), .mem_we(mwe[2]),
    .mem_addr_src(mas[2]), .alu_op(aop[2]), .alu_a_src(asrc[2]),
    .alu_b_src(bsrc[2]), .branch_cond(bc[2]), .reg_write_en(rwe[2]),
    .rd_src(rds[2]), .illegal_instr(ill[2]), .state(st[2]),
    .instret(cnt2));

  function automatic obs_t get_obs(int s);
    obs_t o;
    o.st   = st[s];
    o.irw  = irw[s];
    o.pcw  = pcw[s];
    o.pcs  = pcs[s];
    o.mreq = mreq[s];
    o.mwe  = mwe[s];
    o.mas  = mas[s];
    o.aop  = aop[s];
    o.asrc = asrc[s];
    o.bsrc = bsrc[s];
    o.bc   = bc[s];
    o.rwe  = rwe[s];
    o.rds  = rds[s];
    o.ill  = ill[s];
    o.cnt  = (s == 0) ? cnt0 : (s == 1) ? cnt1 : {28'd0, cnt2};
    return o;
  endfunction

  always @(negedge clk) begin
    if (q.size() != 0) begin
      item_t it;
      obs_t  a;
      it = q.pop_front();
      a  = get_obs(sel);
      checks++;
      if (a !== it.e) begin
        errors++;
        $display("FAIL %s: state %0d got %h, want state %0d %h",
                 it.nm, a.st, a, it.e.st, it.e);
      end
    end
  end

  function automatic obs_t base(logic [2:0] s);
    obs_t e;
    e     = '0;
    e.st  = s;
    e.bc  = 3'b010;
    e.cnt = cnt;
    return e;
  endfunction

  function automatic obs_t fetch(logic rdy);
    obs_t e;
    e      = base(3'd0);
    e.mreq = 1'b1;
    e.irw  = rdy;
    return e;
  endfunction

  function automatic obs_t memc(logic rdy, logic store);
    obs_t e;
    e      = base(3'd3);
    e.mreq = 1'b1;
    e.mas  = 1'b1;
    e.mwe  = store;
    e.pcw  = store & rdy;
    return e;
  endfunction

  function automatic obs_t wb(logic load);
    obs_t e;
    e     = base(3'd4);
    e.rwe = 1'b1;
    e.rds = load ? 2'b01 : 2'b00;
    e.pcw = 1'b1;
    return e;
  endfunction

  task automatic cyc(input obs_t e, input string nm);
    item_t it;
    e.cnt = e.cnt & mask;
    it.nm = nm;
    it.e  = e;
    q.push_back(it);
    @(posedge clk);
    #1;
  endtask

  task automatic run_alu(input logic [31:0] ins, input logic [3:0] op,
                         input logic [1:0] as, input logic bs,
                         input string nm);
    obs_t e;
    instr = ins;
    mem_ready = 1'b1;
    cyc(fetch(1'b1), {nm, "_fetch"});
    cyc(base(3'd1), {nm, "_decode"});
    e      = base(3'd2);
    e.aop  = op;
    e.asrc = as;
    e.bsrc = bs;
    cyc(e, {nm, "_exec"});
    cyc(wb(1'b0), {nm, "_wb"});
    cnt++;
  endtask

  task automatic run_ctl(input logic [31:0] ins, input logic bt,
                         input logic [1:0] ps, input logic [2:0] cond,
                         input logic [1:0] as, input logic we,
                         input logic [1:0] rs, input string nm);
    obs_t e;
    instr = ins;
    mem_ready = 1'b1;
    branch_taken = bt;
    cyc(fetch(1'b1), {nm, "_fetch"});
    cyc(base(3'd1), {nm, "_decode"});
    e      = base(3'd2);
    e.asrc = as;
    e.bc   = cond;
    e.pcw  = 1'b1;
    e.pcs  = ps;
    e.rwe  = we;
    e.rds  = rs;
    cyc(e, {nm, "_exec"});
    cnt++;
    branch_taken = 1'b0;
  endtask

  initial begin
    obs_t e;
    rst_n = 1'b0;
    instr = 32'h0000_0013;
    mem_ready = 1'b1;
    branch_taken = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    cyc(base(3'd0), "reset_state");

    rst_n = 1'b1;
    run_alu(32'h0020_81B3, 4'b0000, 2'b01, 1'b1, "add");
    mem_ready = 1'b0;
    cyc(fetch(1'b0), "fetch_wait1");
    cyc(fetch(1'b0), "fetch_wait2");

    instr = 32'h0000_A183;
    mem_ready = 1'b1;
    cyc(fetch(1'b1), "lw_fetch");
    cyc(base(3'd1), "lw_decode");
    e = base(3'd2);
    e.asrc = 2'b01;
    cyc(e, "lw_exec");
    mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) cyc(memc(1'b0, 1'b0), "lw_mem_wait");
    mem_ready = 1'b1;
    cyc(memc(1'b1, 1'b0), "lw_mem_done");
    cyc(wb(1'b1), "lw_wb");
    cnt++;

    run_ctl(32'h0020_8463, 1'b1, 2'b01, 3'b000, 2'b00, 1'b0, 2'b00,
            "beq_taken");
    run_ctl(32'h0020_8463, 1'b0, 2'b00, 3'b000, 2'b00, 1'b0, 2'b00,
            "beq_not");
    run_ctl(32'h0000_80E7, 1'b0, 2'b10, 3'b011, 2'b01, 1'b1, 2'b10,
            "jalr");
    run_ctl(32'h0080_00EF, 1'b1, 2'b01, 3'b011, 2'b00, 1'b1, 2'b10,
            "jal");
    run_alu(32'h4020_8133, 4'b1000, 2'b01, 1'b1, "sub");
    run_alu(32'h4030_D093, 4'b1101, 2'b01, 1'b0, "srai");
    run_alu(32'hFFF0_0093, 4'b0000, 2'b01, 1'b0, "addi_neg");
    run_alu(32'h0000_12B7, 4'b0000, 2'b10, 1'b0, "lui");
    run_alu(32'h0000_1297, 4'b0000, 2'b00, 1'b0, "auipc");

    instr = 32'h0020_A023;
    mem_ready = 1'b1;
    cyc(fetch(1'b1), "sw_fetch");
    cyc(base(3'd1), "sw_decode");
    e = base(3'd2);
    e.asrc = 2'b01;
    cyc(e, "sw_exec");
    mem_ready = 1'b0;
    cyc(memc(1'b0, 1'b1), "sw_mem_wait");
    mem_ready = 1'b1;
    cyc(memc(1'b1, 1'b1), "sw_mem_done");
    cnt++;
    mem_ready = 1'b0;
    cyc(fetch(1'b0), "sw_retired");

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sel = 1;
    cnt = 0;
    instr = 32'h0020_A023;
    mem_ready = 1'b1;
    cyc(fetch(1'b1), "nols_fetch");
    cyc(base(3'd1), "nols_decode");
    e = base(3'd5);
    e.ill = 1'b1;
    cyc(e, "trap1");
    cyc(e, "trap2");
    rst_n = 1'b0;
    cyc(e, "trap_in_reset");
    rst_n = 1'b1;
    instr = 32'h0000_12B7;
    cyc(fetch(1'b1), "trap_cleared");
    cyc(base(3'd1), "nolui_decode");
    cyc(e, "nolui_trap");

    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    sel = 2;
    cnt = 0;
    mask = 32'h0000_000F;
    for (int i = 0; i < 17; i++)
      run_alu(32'h0020_81B3, 4'b0000, 2'b01, 1'b1, "wrap_add");
    instr = 32'h0020_A023;
    cyc(fetch(1'b1), "wrap_sw_fetch");
    cyc(base(3'd1), "wrap_sw_decode");
    e = base(3'd2);
    e.asrc = 2'b01;
    cyc(e, "wrap_sw_exec");
    mem_ready = 1'b0;
    cyc(memc(1'b0, 1'b1), "wrap_sw_wait");
    rst_n = 1'b0;
    mem_ready = 1'b1;
    e = base(3'd3);
    e.mas = 1'b1;
    cyc(e, "mem_in_reset");
    rst_n = 1'b1;
    mem_ready = 1'b0;
    cnt = 0;
    cyc(fetch(1'b0), "after_mem_reset");

    @(negedge clk);
    #1;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
